ov7670_sensor_emu: RTL

//  Transmit-side model of the OV7670 parallel video port: generates PCLK, VSYNC, HREF and D[7:0]

---
 rtl/ov7670_emu_pkg.sv | 14 +
 rtl/ov7670_sensor_emu_if.sv | 23 ++
 rtl/ov7670_emu_pixel.sv | 42 ++++
 rtl/ov7670_sensor_emu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ov7670_emu_pkg.sv
// Shared types and constants for the OV7670 sensor emulator.
package ov7670_emu_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    typedef enum logic [1:0] {PAT_RAMP, PAT_BARS, PAT_XOR, PAT_ALT} pattern_t;

    // RGB565 colour bars, left to right
    localparam logic [15:0] BAR_COLOUR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/ov7670_sensor_emu_if.sv
// Emulated OV7670 video port: run/pattern controls in, sensor pins and frame status out.
interface ov7670_sensor_emu_if;

    logic        en;
    logic [1:0]  pattern;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  en, pattern,
        output pclk, vsync, href, d, frame_start, frame_cnt
    );

    modport slave (
        output en, pattern,
        input  pclk, vsync, href, d, frame_start, frame_cnt
    );

endinterface

// File: rtl/ov7670_emu_pixel.sv
// Combinational test-pattern byte generator for the active part of a line.
module ov7670_emu_pixel
    import ov7670_emu_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned BPP      = 2,
    parameter int unsigned HW       = 11
) (
    input  pattern_t        pattern_i,
    input  logic [HW-1:0]   hcnt_i,
    input  logic [7:0]      line_i,
    input  logic [7:0]      frame_lsb_i,
    output logic [7:0]      byte_o
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [31:0] px;
    logic [2:0]  bar_idx;
    logic [15:0] colour;
    logic        low_byte;

    always_comb begin
        px       = 32'(hcnt_i) / BPP;
        bar_idx  = 3'(px / BAR_W);
        colour   = BAR_COLOUR[bar_idx];
        // with one byte per pixel only the high byte of each colour is sent
        low_byte = (BPP == 2) && hcnt_i[0];
    end

    always_comb begin
        byte_o = '0;
        unique case (pattern_i)
            PAT_RAMP: byte_o = 8'(hcnt_i);
            PAT_BARS: byte_o = low_byte ? colour[7:0] : colour[15:8];
            PAT_XOR:  byte_o = line_i ^ frame_lsb_i;
            PAT_ALT:  byte_o = hcnt_i[0] ? 8'hAA : 8'h55;
            default:  byte_o = '0;
        endcase
    end

endmodule

// File: rtl/ov7670_sensor_emu.sv
// OV7670 parallel-port transmitter model: pclk = clk25/2, frame/line timing FSM and
// registered vsync/href/d that change only on pclk falling edges.
module ov7670_sensor_emu
    import ov7670_emu_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned BPP      = 2
) (
    input  logic                clk25,
    input  logic                rst_n,
    ov7670_sensor_emu_if.master vid
);

    localparam int unsigned LINE_BEATS = (H_ACTIVE + H_BLANK) * BPP;
    localparam int unsigned HREF_BEATS = H_ACTIVE * BPP;
    localparam int unsigned HW         = $clog2(LINE_BEATS);
    localparam int unsigned V_MAX_A    = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int unsigned V_MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned V_MAX      = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int unsigned VW         = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(LINE_BEATS - 1);
    localparam logic [HW-1:0] H_HREF = HW'(HREF_BEATS);

    state_t      state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [VW-1:0] v_last;
    pattern_t    pattern_q;
    logic [15:0] frame_cnt_q;
    logic        pclk_q;
    logic        vsync_q;
    logic        href_q;
    logic [7:0]  d_q;
    logic        frame_start_q;

    logic        beat;
    logic        line_last;
    logic        state_done;
    logic        frame_done;
    logic        latch_pat;
    logic        href_d;
    logic [7:0]  pix_byte;

    // a beat ends on the clk25 edge that drives pclk from 1 to 0
    assign beat       = pclk_q;
    assign line_last  = (hcnt_q == H_LAST);
    assign state_done = line_last && (vcnt_q == v_last);
    assign href_d     = (state_q == ACTIVE) && (hcnt_q < H_HREF);

    always_comb begin
        v_last = '0;
        unique case (state_q)
            VSYNC:   v_last = VW'(V_SYNC - 1);
            VBACK:   v_last = VW'(V_BACK - 1);
            ACTIVE:  v_last = VW'(V_ACTIVE - 1);
            VFRONT:  v_last = VW'(V_FRONT - 1);
            default: v_last = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        frame_done = 1'b0;
        latch_pat  = 1'b0;
        if (state_q == IDLE) begin
            if (vid.en) begin
                state_d   = VSYNC;
                latch_pat = 1'b1;
            end
        end else begin
            hcnt_d = line_last ? '0 : hcnt_q + HW'(1);
            if (line_last) begin
                vcnt_d = state_done ? '0 : vcnt_q + VW'(1);
            end
            if (state_done) begin
                unique case (state_q)
                    VSYNC:  state_d = VBACK;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: state_d = VFRONT;
                    VFRONT: begin
                        frame_done = 1'b1;
                        if (vid.en) begin
                            state_d   = VSYNC;
                            latch_pat = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    ov7670_emu_pixel #(
        .H_ACTIVE (H_ACTIVE),
        .BPP      (BPP),
        .HW       (HW)
    ) u_pixel (
        .pattern_i   (pattern_q),
        .hcnt_i      (hcnt_q),
        .line_i      (8'(vcnt_q)),
        .frame_lsb_i (frame_cnt_q[7:0]),
        .byte_o      (pix_byte)
    );

    // pins reflect the position of the beat just finished, one beat behind the FSM
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pattern_q     <= PAT_RAMP;
            frame_cnt_q   <= '0;
            pclk_q        <= 1'b0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pclk_q        <= ~pclk_q;
            frame_start_q <= 1'b0;
            if (beat) begin
                state_q       <= state_d;
                hcnt_q        <= hcnt_d;
                vcnt_q        <= vcnt_d;
                vsync_q       <= (state_q == VSYNC);
                href_q        <= href_d;
                d_q           <= href_d ? pix_byte : 8'h00;
                frame_start_q <= (state_q == VSYNC) && (hcnt_q == '0) && (vcnt_q == '0);
                if (frame_done) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                if (latch_pat) begin
                    pattern_q <= pattern_t'(vid.pattern);
                end
            end
        end
    end

    assign vid.pclk        = pclk_q;
    assign vid.vsync       = vsync_q;
    assign vid.href        = href_q;
    assign vid.d           = d_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule
